// File: rtl/mac_cfg_pkg.sv
// Shared types and helpers for the configurable multiply-accumulate block.
package mac_cfg_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Widest accumulator the saturating adder supports.
  localparam int SAT_MAX_W = 64;

  // Add two w-bit values held in the low bits of 64-bit words.
  // sat=0 wraps modulo 2^w; sat=1 clamps to the unsigned or signed range of w bits.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   w,
    input logic                 is_signed,
    input logic                 sat
  );
    logic [SAT_MAX_W:0]   full;
    logic [SAT_MAX_W-1:0] mask;
    logic [SAT_MAX_W-1:0] sum;
    logic [SAT_MAX_W-1:0] s_max;
    logic [SAT_MAX_W-1:0] res;
    logic [6:0]           w_idx;
    logic [5:0]           msb_idx;
    logic                 carry;
    logic                 ovf;
    w_idx   = 7'(w);
    msb_idx = 6'(w - 1);
    mask    = (w >= SAT_MAX_W) ? {SAT_MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
    full    = {1'b0, a & mask} + {1'b0, b & mask};
    sum     = full[SAT_MAX_W-1:0] & mask;
    carry   = full[w_idx];
    // Signed overflow: operands agree in sign but the sum does not.
    ovf     = (a[msb_idx] == b[msb_idx]) && (sum[msb_idx] != a[msb_idx]);
    s_max   = mask >> 1;
    res     = sum;
    if (sat) begin
      if (is_signed) begin
        if (ovf) res = a[msb_idx] ? (mask & ~s_max) : s_max;
      end else if (carry) begin
        res = mask;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_cfg_mul.sv
// Fixed-latency signed/unsigned multiplier: start pulse latches operands,
// done is high in the last of p_ncycles busy cycles.
module mac_cfg_mul
  import mac_cfg_pkg::*;
#(
  parameter int p_width   = 8,
  parameter int p_ncycles = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [p_width-1:0]     i_a,
  input  logic [p_width-1:0]     i_b,
  input  logic                   i_signed,
  output logic                   o_done,
  output logic [2*p_width-1:0]   o_product
);

  localparam int CW = $clog2(p_ncycles + 1);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [p_width-1:0] r_a;
  logic [p_width-1:0] r_b;
  logic [2*p_width-1:0] w_a_ext;
  logic [2*p_width-1:0] w_b_ext;

  // Busy flag and latency down-counter.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(p_ncycles - 1);
    end else if (r_busy) begin
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end

  // Operand capture on start.
  // NOTE: operand registers carry no reset; they are only consumed while r_busy, which is reset.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_a <= i_a;
      r_b <= i_b;
    end
  end

  // Extend both operands to product width; the low 2*p_width bits of the
  // product are then correct for either signedness.
  assign w_a_ext   = {{p_width{i_signed & r_a[p_width-1]}}, r_a};
  assign w_b_ext   = {{p_width{i_signed & r_b[p_width-1]}}, r_b};
  assign o_product = w_a_ext * w_b_ext;
  assign o_done    = r_busy && (r_cnt == '0);

endmodule

// File: rtl/mac_cfg.sv
// Configurable multiply-accumulate: accumulates a group of cfg_nmsgs products
// (signed/unsigned, wrapping/saturating) and returns the sum as one response.
module mac_cfg
  import mac_cfg_pkg::*;
#(
  parameter int p_width     = 8,
  parameter int p_acc_width = 2*p_width,
  parameter int p_ncycles   = 3,
  parameter int p_max_nmsgs = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_val,
  output logic                              req_rdy,
  input  logic [2*p_width-1:0]              req_msg,
  input  logic [$clog2(p_max_nmsgs+1)-1:0]  cfg_nmsgs,
  input  logic                              cfg_signed,
  input  logic                              cfg_sat,
  output logic                              resp_val,
  input  logic                              resp_rdy,
  output logic [p_acc_width-1:0]            resp_msg
);

  localparam int NW = $clog2(p_max_nmsgs + 1);
  localparam int PW = 2 * p_width;

  state_e               r_state;
  logic [p_acc_width-1:0] r_acc;
  logic [NW-1:0]        r_cnt;
  logic [NW-1:0]        r_nmsgs;
  logic                 r_signed;
  logic                 r_sat;

  logic                 w_accept;
  logic                 w_mul_done;
  logic                 w_last;
  logic [PW-1:0]        w_prod;
  logic [p_acc_width-1:0] w_prod_ext;
  logic [p_acc_width-1:0] w_sum;

  assign req_rdy  = (r_state == IDLE);
  assign resp_val = (r_state == RESP);
  assign resp_msg = r_acc;
  assign w_accept = req_val && req_rdy;

  mac_cfg_mul #(
    .p_width   (p_width),
    .p_ncycles (p_ncycles)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_accept),
    .i_a       (req_msg[PW-1:p_width]),
    .i_b       (req_msg[p_width-1:0]),
    .i_signed  (r_signed),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // Widen the product to the accumulator, sign- or zero-extending.
  if (p_acc_width > PW) begin : g_ext
    assign w_prod_ext = {{(p_acc_width-PW){r_signed & w_prod[PW-1]}}, w_prod};
  end else begin : g_noext
    assign w_prod_ext = w_prod;
  end

  assign w_sum  = p_acc_width'(sat_add(64'(r_acc), 64'(w_prod_ext), p_acc_width, r_signed, r_sat));
  assign w_last = ({1'b0, r_cnt} + (NW+1)'(1)) == {1'b0, r_nmsgs};

  // Control FSM, group counter, latched configuration and accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_nmsgs  <= NW'(1);
      r_signed <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_val) begin
            r_state <= MUL;
            // Configuration is sampled only at the first product of a group.
            if (r_cnt == '0) begin
              r_nmsgs  <= (cfg_nmsgs == '0) ? NW'(1) : cfg_nmsgs;
              r_signed <= cfg_signed;
              r_sat    <= cfg_sat;
            end
          end
        end
        MUL: begin
          if (w_mul_done) begin
            r_acc   <= w_sum;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= w_last ? RESP : IDLE;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_cfg.sv
// Self-checking bench for mac_cfg: directed scenarios plus randomized groups
// checked against an arithmetic reference model.
module tb_mac_cfg;

  localparam int W    = 8;
  localparam int AW   = 16;
  localparam int NC   = 3;
  localparam int MAXN = 16;
  localparam int NW   = $clog2(MAXN + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val;
  logic          req_rdy;
  logic [2*W-1:0] req_msg;
  logic [NW-1:0] cfg_nmsgs;
  logic          cfg_signed;
  logic          cfg_sat;
  logic          resp_val;
  logic          resp_rdy;
  logic [AW-1:0] resp_msg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_acc = 0;

  // Reference model state
  int     m_cnt = 0;
  int     m_n   = 1;
  bit     m_sgn = 1'b0;
  bit     m_sat = 1'b0;
  longint m_acc = 0;

  mac_cfg #(
    .p_width     (W),
    .p_acc_width (AW),
    .p_ncycles   (NC),
    .p_max_nmsgs (MAXN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_msg    (req_msg),
    .cfg_nmsgs  (cfg_nmsgs),
    .cfg_signed (cfg_signed),
    .cfg_sat    (cfg_sat),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_msg   (resp_msg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One accumulation step of the reference: plain integer add, then clamp or wrap.
  function automatic longint acc_step(input longint acc, input longint p, input bit sgn, input bit sat);
    longint s;
    longint lo;
    longint hi;
    s  = acc + p;
    lo = sgn ? -(longint'(1) <<< (AW-1)) : 0;
    hi = sgn ? ((longint'(1) <<< (AW-1)) - 1) : ((longint'(1) <<< AW) - 1);
    if (sat) begin
      if (s < lo) s = lo;
      if (s > hi) s = hi;
    end else begin
      s = s & ((longint'(1) <<< AW) - 1);
      if (sgn && s > hi) s = s - (longint'(1) <<< AW);
    end
    return s;
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    m_acc = 0;
  endtask

  // Wait for req_rdy, present one request for a single cycle, update the model.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input int n,
                      input bit sgn, input bit sat, input bit chk_gap, output bit done);
    int low;
    longint prod;
    low = 0;
    while (req_rdy !== 1'b1 && low < 50) begin
      @(negedge clk);
      low++;
    end
    check("req_rdy_before_send", req_rdy, 1);
    if (chk_gap) check("req_rdy_gap", low, NC);
    req_val    = 1'b1;
    req_msg    = {a, b};
    cfg_nmsgs  = NW'(n);
    cfg_signed = sgn;
    cfg_sat    = sat;
    @(negedge clk);
    req_val = 1'b0;
    check("req_rdy_after_accept", req_rdy, 0);
    if (chk_gap) check("accept_interval", cyc - last_acc, NC + 1);
    last_acc = cyc;
    if (m_cnt == 0) begin
      m_n   = (n == 0) ? 1 : n;
      m_sgn = sgn;
      m_sat = sat;
    end
    if (m_sgn) prod = longint'($signed(a)) * longint'($signed(b));
    else       prod = longint'(a) * longint'(b);
    m_acc = acc_step(m_acc, prod, m_sgn, m_sat);
    m_cnt++;
    done = (m_cnt == m_n);
  endtask

  // Wait for the response, check it, optionally stall it, then complete the handshake.
  task automatic get_resp(input string tag, input logic [AW-1:0] exp, input int hold);
    int waited;
    waited = 0;
    while (resp_val !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("resp_val_seen", resp_val, 1);
    check("resp_latency", cyc - last_acc, NC);
    check(tag, resp_msg, exp);
    req_val = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_msg", resp_msg, exp);
      check("hold_val", resp_val, 1);
      check("hold_req_rdy", req_rdy, 0);
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    @(negedge clk);
    resp_rdy = 1'b0;
    check("post_resp_req_rdy", req_rdy, 1);
    check("post_resp_val", resp_val, 0);
    check("post_resp_acc_clear", resp_msg, 0);
    model_clear();
  endtask

  initial begin
    bit done;
    bit first;
    int guard;
    reset      = 1'b1;
    req_val    = 1'b0;
    req_msg    = '0;
    cfg_nmsgs  = '0;
    cfg_signed = 1'b0;
    cfg_sat    = 1'b0;
    resp_rdy   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_req_rdy", req_rdy, 1);
    check("reset_resp_val", resp_val, 0);
    check("reset_resp_msg", resp_msg, 0);

    // Unsigned group of four with back-to-back requests
    send(8'd2,  8'd3,  4, 1'b0, 1'b0, 1'b0, done);
    send(8'd4,  8'd5,  4, 1'b0, 1'b0, 1'b1, done);
    send(8'd1,  8'd1,  4, 1'b0, 1'b0, 1'b1, done);
    send(8'd10, 8'd10, 4, 1'b0, 1'b0, 1'b1, done);
    get_resp("unsigned_sum4", 16'd127, 0);

    // Signed group
    send(8'hFD, 8'd4,  2, 1'b1, 1'b0, 1'b0, done);
    send(8'd2,  8'hFB, 2, 1'b1, 1'b0, 1'b1, done);
    get_resp("signed_sum2", 16'hFFEA, 0);

    // Saturation and wrap
    send(8'd255, 8'd255, 2, 1'b0, 1'b1, 1'b0, done);
    send(8'd255, 8'd255, 2, 1'b0, 1'b1, 1'b1, done);
    get_resp("unsigned_sat", 16'hFFFF, 0);
    send(8'd255, 8'd255, 2, 1'b0, 1'b0, 1'b0, done);
    send(8'd255, 8'd255, 2, 1'b0, 1'b0, 1'b1, done);
    get_resp("unsigned_wrap", 16'd64514, 0);
    send(8'h80, 8'h80, 3, 1'b1, 1'b1, 1'b0, done);
    send(8'h80, 8'h80, 3, 1'b1, 1'b1, 1'b1, done);
    send(8'h80, 8'h80, 3, 1'b1, 1'b1, 1'b1, done);
    get_resp("signed_sat", 16'h7FFF, 0);

    // Response backpressure, then a fresh group with no carry-over
    send(8'd3, 8'd7, 1, 1'b0, 1'b0, 1'b0, done);
    get_resp("backpressure", 16'd21, 5);
    send(8'd5, 8'd5, 1, 1'b0, 1'b0, 1'b0, done);
    get_resp("after_backpressure", 16'd25, 0);

    // Reset during the second MUL cycle of a partially accumulated group
    send(8'd9, 8'd9, 2, 1'b0, 1'b0, 1'b0, done);
    send(8'd3, 8'd3, 2, 1'b0, 1'b0, 1'b1, done);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check("midreset_req_rdy", req_rdy, 1);
    check("midreset_resp_val", resp_val, 0);
    check("midreset_resp_msg", resp_msg, 0);
    repeat (4) @(negedge clk);
    check("midreset_no_resp", resp_val, 0);
    send(8'd1, 8'd1, 1, 1'b0, 1'b0, 1'b0, done);
    get_resp("after_midreset", 16'd1, 0);

    // Config edge cases: nmsgs=0 acts as 1; mid-group config ignored
    send(8'd7, 8'd6, 0, 1'b0, 1'b0, 1'b0, done);
    get_resp("nmsgs_zero", 16'd42, 0);
    send(8'd200, 8'd2, 2, 1'b0, 1'b0, 1'b0, done);
    send(8'hFF,  8'd1, 1, 1'b1, 1'b1, 1'b1, done);
    get_resp("cfg_change_ignored", 16'd655, 0);

    // Randomized groups with random mid-group config noise and stalls
    for (int g = 0; g < 30; g++) begin
      first = 1'b1;
      guard = 0;
      done  = 1'b0;
      while (!done && guard < 20) begin
        send(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), !first, done);
        first = 1'b0;
        guard++;
      end
      get_resp("random_group", AW'(m_acc), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_cfg.md
MAC_CFG -- requirements
Module: mac_cfg

Interface
REQ-001 SHALL have parameter p_width, default 8, operand width.
REQ-002 SHALL have parameter p_acc_width, default 2*p_width, accumulator/result width; legal range p_acc_width >= 2*p_width.
REQ-003 SHALL have parameter p_ncycles, default 3, multiply latency in cycles; legal range p_ncycles >= 1.
REQ-004 SHALL have parameter p_max_nmsgs, default 16, maximum products per accumulation group.
REQ-005 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req_val  input  1  request valid.
REQ-008 SHALL have port req_rdy  output  1  request ready.
REQ-009 SHALL have port req_msg  input  2*p_width  operands: a = [2*p_width-1:p_width], b = [p_width-1:0].
REQ-010 SHALL have port cfg_nmsgs  input  $clog2(p_max_nmsgs+1)  products per group.
REQ-011 SHALL have port cfg_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-012 SHALL have port cfg_sat  input  1  1 = saturating accumulate; 0 = wrap-around accumulate.
REQ-013 SHALL have port resp_val  output  1  response valid.
REQ-014 SHALL have port resp_rdy  input  1  response ready.
REQ-015 SHALL have port resp_msg  output  p_acc_width  accumulated result.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, RESP.
- IDLE: req_rdy=1.
- MUL: req_rdy=0, resp_val=0.
- RESP: resp_val=1, req_rdy=0.
REQ-017 SHALL transition IDLE->MUL on req_val&&req_rdy, latching a and b.
REQ-018 SHALL remain in MUL for exactly p_ncycles cycles, counted by a down-counter.
REQ-019 SHALL, on the final MUL cycle edge:
- add the full-width product into acc;
- increment cnt;
- go to RESP if cnt+1 == nmsgs, else to IDLE.
REQ-020 SHALL latch cfg_nmsgs, cfg_signed and cfg_sat only when a request is accepted with cnt==0; config changes mid-group SHALL be ignored.
REQ-021 SHALL treat a latched nmsgs of 0 as 1.
REQ-022 SHALL form the product at 2*p_width bits and extend it to p_acc_width: sign-extend when signed, zero-extend when unsigned.
REQ-023 SHALL, when sat=1, clamp each addition to [0, 2^p_acc_width-1] if unsigned or [-2^(p_acc_width-1), 2^(p_acc_width-1)-1] if signed; when sat=0, wrap modulo 2^p_acc_width.
REQ-024 SHALL drive resp_msg = acc and hold it stable while resp_val=1 and resp_rdy=0.
REQ-025 SHALL, on resp_val&&resp_rdy, clear acc and cnt and go to IDLE; the next request is accepted no earlier than the following cycle.
REQ-026 SHALL derive req_rdy and resp_val from registered state only, with no combinational path from req_val or resp_rdy.
REQ-027 SHALL give an accepted request one group slot every p_ncycles+1 cycles under continuous req_val; the final product appears as resp_val exactly p_ncycles cycles after its acceptance edge.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, set state=IDLE, acc=0, cnt=0, and clear the latched config (nmsgs=1, signed=0, sat=0).
REQ-029 SHALL, on reset mid-MUL or mid-RESP, abandon the partial group; the cycle after reset deasserts, req_rdy=1, resp_val=0 and resp_msg=0.

Structure
REQ-030 SHALL place the state enum (IDLE/MUL/RESP) and a saturate-add helper function in shared package mac_cfg_pkg.
REQ-031 SHALL implement the operand datapath as one sub-module, mac_cfg_mul: a fixed-latency signed/unsigned multiplier with a start/done pulse interface.

Verification (p_width=8, p_acc_width=16, p_ncycles=3)
REQ-032 SHALL cover: unsigned, nmsgs=4, (2,3),(4,5),(1,1),(10,10) -> resp_msg=127; each req_rdy gap exactly 3 cycles.
REQ-033 SHALL cover: signed, nmsgs=2, (-3,4),(2,-5) -> resp_msg=0xFFEA (-22).
REQ-034 SHALL cover saturation, nmsgs=2 or 3:
- unsigned (255,255)x2, sat=1 -> 0xFFFF;
- same with sat=0 -> 64514;
- signed (-128,-128)x3, sat=1 -> 0x7FFF.
REQ-035 SHALL cover backpressure: resp_rdy=0 for 5 cycles -> resp_msg stable and req_rdy=0; after the handshake, next group (5,5), nmsgs=1 -> 25, no carry-over.
REQ-036 SHALL cover reset asserted in the 2nd MUL cycle -> next cycle req_rdy=1, resp_val=0; a new group (1,1), nmsgs=1 -> 1.
REQ-037 SHALL cover config edge cases: cfg_nmsgs=0 with (7,6) -> 42; cfg_nmsgs changed 2->1 after the first accept -> group still completes after 2 products.
